fifo_rd_stream: RTL

Read-side consumer for the dual-clock FIFO, living entirely in the read clock domain. Drives the FIFO pop strobe from the empty flag, absorbs the FIFO memory's one-cycle read latency, and presents the words downstream as a valid/ready stream. A 2-entry output buffer with pop crediting sustains one word per cycle under continuous `i_ready`, and no word is ever dropped or duplicated while downstream stalls.

---
 rtl/fifo_rd_stream.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the dual-clock FIFO: pops with credit, absorbs the one-cycle read latency
// in a 2-entry buffer, and presents a valid/ready stream. Optional pop counter: FIFO_RD_POP_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_fifo_rd_en,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
`ifdef FIFO_RD_POP_CNT_EN
    ,
    output logic [15:0]           o_pop_cnt
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic                  xfer_s;
    logic [2:0]            fill_s;

    // Stream outputs, transfer handshake and pop crediting
    always_comb begin
        o_valid = (occ_q != OCC_EMPTY);
        if (head_q) begin
            o_data = slot1_q;
        end else begin
            o_data = slot0_q;
        end
        xfer_s = o_valid & i_ready;
        // Words committed to the buffer after this edge; a slot freed now is re-credited at once.
        fill_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer_s};
        o_fifo_rd_en = !i_rst && !i_fifo_empty && (fill_s < 3'd2);
    end

    // Next-state: capture of the in-flight word, delivery, occupancy
    always_comb begin
        inflight_d = o_fifo_rd_en;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        tail_d     = tail_q;
        head_d     = head_q;
        occ_d      = occ_q;

        if (inflight_q) begin
            if (tail_q) begin
                slot1_d = i_fifo_rd_data;
            end else begin
                slot0_d = i_fifo_rd_data;
            end
            tail_d = ~tail_q;
        end else begin
            tail_d = tail_q;
        end

        if (xfer_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end

        case (fill_s)
            3'd0:    occ_d = OCC_EMPTY;
            3'd1:    occ_d = OCC_ONE;
            3'd2:    occ_d = OCC_TWO;
            default: occ_d = OCC_TWO;
        endcase
    end

    // Buffer state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            slot0_q    <= {DATA_WIDTH{1'b0}};
            slot1_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

`ifdef FIFO_RD_POP_CNT_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;

    // Delivered-word counter, wraps naturally at 16 bits
    always_comb begin
        if (xfer_s) begin
            pop_cnt_d = pop_cnt_q + 16'd1;
        end else begin
            pop_cnt_d = pop_cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pop_cnt_q <= 16'd0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign o_pop_cnt = pop_cnt_q;
`endif

endmodule
